// File: rtl/uart_pkg.sv
// Shared types and constants for the framed UART receive path.
package uart_pkg;

    localparam int DEF_BYTE_SIZE      = 8;
    localparam int DEF_FULL_DATA_SIZE = 40;

    typedef enum logic [1:0] {
        B_IDLE,
        B_START,
        B_DATA,
        B_STOP
    } byte_state_t;

    typedef enum logic [1:0] {
        F_CMD,
        F_LEN,
        F_DATA,
        F_DONE
    } frame_state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_FRAMING = 2'd1;
    localparam logic [1:0] ERR_LEN     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // Payload bytes that fit in a frame word after CMD and LEN.
    function automatic int max_pay(input int full_size, input int byte_size);
        return full_size / byte_size - 2;
    endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 character receiver: start detect, mid-bit sampling, LSB-first shift, stop check.
// byte_valid / frame_err are single-cycle strobes in the stop-sample cycle.
// idle is high only while waiting for a start and no start is being detected.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int BYTE_SIZE    = DEF_BYTE_SIZE,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_bit,
    output logic [BYTE_SIZE-1:0] data_byte,
    output logic                 byte_valid,
    output logic                 frame_err,
    output logic                 idle
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (BYTE_SIZE > 1) ? $clog2(BYTE_SIZE) : 1;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BYTE_SIZE - 1);

    byte_state_t          state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_next;
    logic [BYTE_SIZE-1:0] shreg, shreg_next;
    logic                 line_high;
    logic                 detect;

    // A start needs a 1->0 edge, so a held-low line (break) cannot retrigger.
    assign detect    = (state == B_IDLE) && line_high && !in_bit;
    assign idle      = (state == B_IDLE) && !detect;
    assign data_byte = shreg;

    // Control state register; line_high remembers the previous line level.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= B_IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            line_high <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            bit_cnt   <= bit_cnt_next;
            line_high <= in_bit;
        end
    end

    // Data shift register, no reset needed.
    always_ff @(posedge CLK) begin
        shreg <= shreg_next;
    end

    // Bit timing, sampling and start/stop decisions.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_cnt_next = bit_cnt;
        shreg_next   = shreg;
        byte_valid   = 1'b0;
        frame_err    = 1'b0;
        case (state)
            B_IDLE: begin
                if (detect) begin
                    bit_cnt_next = '0;
                    // The detect cycle is cycle 0 of the start bit.
                    if (CLKS_PER_BIT == 1) begin
                        state_next = B_DATA;
                        cnt_next   = '0;
                    end else begin
                        state_next = B_START;
                        cnt_next   = CNT_W'(1);
                    end
                end
            end
            B_START: begin
                if (cnt == CNT_HALF && in_bit) begin
                    state_next = B_IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = B_DATA;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            B_DATA: begin
                if (cnt == CNT_HALF) begin
                    shreg_next = {in_bit, shreg[BYTE_SIZE-1:1]};
                end
                if (cnt == CNT_LAST) begin
                    cnt_next = '0;
                    if (bit_cnt == BIT_LAST) begin
                        state_next = B_STOP;
                    end else begin
                        bit_cnt_next = bit_cnt + BIT_W'(1);
                    end
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            B_STOP: begin
                // Leave at the stop sample so a following start is caught immediately.
                if (cnt == CNT_HALF) begin
                    if (in_bit) begin
                        byte_valid = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                    state_next = B_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = B_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: rtl/uart_frame_rx.sv
// Frame assembler: CMD, LEN, then LEN payload bytes into one wide word.
// Emits a one-cycle out_valid with the frame, or a one-cycle out_err with a cause code.
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter int FULL_DATA_SIZE = DEF_FULL_DATA_SIZE,
    parameter int BYTE_SIZE      = DEF_BYTE_SIZE,
    parameter int CLKS_PER_BIT   = 1,
    parameter int TIMEOUT_CLKS   = 64
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      in_bit,
    output logic [FULL_DATA_SIZE-1:0] out_data,
    output logic                      out_valid,
    output logic                      out_err,
    output logic [1:0]                err_code
);

    localparam int MAX_PAY = max_pay(FULL_DATA_SIZE, BYTE_SIZE);
    localparam int PIDX_W  = (MAX_PAY > 1) ? $clog2(MAX_PAY) : 1;
    localparam int TCNT_W  = $clog2(TIMEOUT_CLKS + 2);
    localparam logic [TCNT_W-1:0]    TCNT_LIMIT = TCNT_W'(TIMEOUT_CLKS);
    localparam logic [BYTE_SIZE-1:0] LEN_MAX    = BYTE_SIZE'(MAX_PAY);

    logic [BYTE_SIZE-1:0]      rx_byte;
    logic                      rx_valid;
    logic                      rx_ferr;
    logic                      rx_idle;

    frame_state_t              fstate, f_next;
    logic [FULL_DATA_SIZE-1:0] shadow, shadow_next;
    logic [FULL_DATA_SIZE-1:0] data_next;
    logic [BYTE_SIZE-1:0]      rem, rem_next;
    logic [PIDX_W-1:0]         pidx, pidx_next;
    logic [TCNT_W-1:0]         tcnt;
    logic                      valid_next;
    logic                      err_next;
    logic [1:0]                code_next;
    logic                      abort;
    logic [1:0]                abort_code;
    logic                      in_frame;
    logic                      timeout;

    uart_byte_rx #(
        .BYTE_SIZE    (BYTE_SIZE),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte_rx (
        .CLK        (CLK),
        .RST        (RST),
        .in_bit     (in_bit),
        .data_byte  (rx_byte),
        .byte_valid (rx_valid),
        .frame_err  (rx_ferr),
        .idle       (rx_idle)
    );

    // Only the gap between bytes of a started frame is timed.
    assign in_frame = (fstate == F_LEN) || (fstate == F_DATA);
    assign timeout  = in_frame && rx_idle && (tcnt == TCNT_LIMIT);

    // Frame control registers and outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fstate    <= F_CMD;
            rem       <= '0;
            pidx      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            fstate    <= f_next;
            rem       <= rem_next;
            pidx      <= pidx_next;
            out_data  <= data_next;
            out_valid <= valid_next;
            out_err   <= err_next;
            err_code  <= code_next;
        end
    end

    // Shadow frame being assembled, no reset needed.
    always_ff @(posedge CLK) begin
        shadow <= shadow_next;
    end

    // Inter-byte idle counter; any start or leaving the frame body clears it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tcnt <= '0;
        end else if (in_frame && rx_idle) begin
            tcnt <= tcnt + TCNT_W'(1);
        end else begin
            tcnt <= '0;
        end
    end

    // Frame next-state, byte placement and abort handling.
    always_comb begin
        f_next      = fstate;
        shadow_next = shadow;
        rem_next    = rem;
        pidx_next   = pidx;
        data_next   = out_data;
        valid_next  = 1'b0;
        err_next    = 1'b0;
        code_next   = err_code;
        abort       = 1'b0;
        abort_code  = ERR_NONE;
        case (fstate)
            F_CMD: begin
                if (rx_ferr) begin
                    abort      = 1'b1;
                    abort_code = ERR_FRAMING;
                end else if (rx_valid) begin
                    shadow_next = '0;
                    shadow_next[FULL_DATA_SIZE-1 -: BYTE_SIZE] = rx_byte;
                    f_next = F_LEN;
                end
            end
            F_LEN: begin
                if (rx_ferr) begin
                    abort      = 1'b1;
                    abort_code = ERR_FRAMING;
                end else if (rx_valid) begin
                    shadow_next[FULL_DATA_SIZE-BYTE_SIZE-1 -: BYTE_SIZE] = rx_byte;
                    if (rx_byte > LEN_MAX) begin
                        abort      = 1'b1;
                        abort_code = ERR_LEN;
                    end else if (rx_byte == '0) begin
                        f_next = F_DONE;
                    end else begin
                        rem_next  = rx_byte;
                        pidx_next = '0;
                        f_next    = F_DATA;
                    end
                end else if (timeout) begin
                    abort      = 1'b1;
                    abort_code = ERR_TIMEOUT;
                end
            end
            F_DATA: begin
                if (rx_ferr) begin
                    abort      = 1'b1;
                    abort_code = ERR_FRAMING;
                end else if (rx_valid) begin
                    shadow_next[BYTE_SIZE*int'(pidx) +: BYTE_SIZE] = rx_byte;
                    pidx_next = pidx + PIDX_W'(1);
                    rem_next  = rem - BYTE_SIZE'(1);
                    if (rem == BYTE_SIZE'(1)) begin
                        f_next = F_DONE;
                    end
                end else if (timeout) begin
                    abort      = 1'b1;
                    abort_code = ERR_TIMEOUT;
                end
            end
            F_DONE: begin
                data_next  = shadow;
                valid_next = 1'b1;
                f_next     = F_CMD;
            end
            default: begin
                f_next = F_CMD;
            end
        endcase
        if (abort) begin
            f_next      = F_CMD;
            shadow_next = '0;
            err_next    = 1'b1;
            code_next   = abort_code;
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: one instance at 1 clk/bit, one at 4 clks/bit.
`timescale 1ns/1ps
module tb_uart_frame_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in1 = 1'b1;
    logic        in4 = 1'b1;
    logic [39:0] data1, data4;
    logic        valid1, valid4, err1, err4;
    logic [1:0]  code1, code4;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int stop_cyc = 0;

    int          nvalid1 = 0, nerr1 = 0, nboth = 0, nvalid4 = 0, nerr4 = 0;
    logic [39:0] ldata1 = '0, ldata4 = '0;
    logic [1:0]  lcode1 = '0;
    int          ecyc1 = 0;
    logic [39:0] vdata1[$];
    int          vcyc1[$];

    always #5 clk = ~clk;

    uart_frame_rx #(.FULL_DATA_SIZE(40), .BYTE_SIZE(8), .CLKS_PER_BIT(1), .TIMEOUT_CLKS(64)) dut1 (
        .CLK(clk), .RST(rst), .in_bit(in1),
        .out_data(data1), .out_valid(valid1), .out_err(err1), .err_code(code1)
    );

    uart_frame_rx #(.FULL_DATA_SIZE(40), .BYTE_SIZE(8), .CLKS_PER_BIT(4), .TIMEOUT_CLKS(64)) dut4 (
        .CLK(clk), .RST(rst), .in_bit(in4),
        .out_data(data4), .out_valid(valid4), .out_err(err4), .err_code(code4)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Record output pulses away from the active edge.
    always @(negedge clk) begin
        if (valid1) begin
            nvalid1 <= nvalid1 + 1;
            ldata1  <= data1;
            vdata1.push_back(data1);
            vcyc1.push_back(cyc);
        end
        if (err1) begin
            nerr1  <= nerr1 + 1;
            lcode1 <= code1;
            ecyc1  <= cyc;
        end
        if (valid1 && err1) nboth <= nboth + 1;
        if (valid4) begin
            nvalid4 <= nvalid4 + 1;
            ldata4  <= data4;
        end
        if (err4) nerr4 <= nerr4 + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input bit sel4, input logic v);
        if (sel4) begin
            in4 = v;
            tick(4);
        end else begin
            in1 = v;
            tick(1);
        end
    endtask

    task automatic send_byte(input bit sel4, input logic [7:0] b, input logic stop);
        drive_bit(sel4, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel4, b[i]);
        drive_bit(sel4, stop);
        stop_cyc = cyc;
        if (sel4) in4 = 1'b1; else in1 = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(3);
        n_checks++; if (data1 !== 40'h0) $display("FAIL reset_data1 got %h want 0", data1); else n_pass++;
        n_checks++; if (valid1 !== 1'b0) $display("FAIL reset_valid1 got %b want 0", valid1); else n_pass++;
        n_checks++; if (err1 !== 1'b0) $display("FAIL reset_err1 got %b want 0", err1); else n_pass++;
        n_checks++; if (code1 !== 2'd0) $display("FAIL reset_code1 got %0d want 0", code1); else n_pass++;
        n_checks++; if (data4 !== 40'h0 || err4 !== 1'b0 || code4 !== 2'd0)
            $display("FAIL reset_dut4 got data=%h err=%b code=%0d want 0/0/0", data4, err4, code4); else n_pass++;
        rst = 1'b0;
        tick(3);
    endtask

    task automatic test_back_to_back;
        int v0, e0, s;
        v0 = nvalid1; e0 = nerr1;
        send_byte(0, 8'h00, 1); send_byte(0, 8'h03, 1); send_byte(0, 8'h47, 1);
        send_byte(0, 8'hbb, 1); send_byte(0, 8'haa, 1);
        s = stop_cyc;
        tick(4);
        n_checks++; if (nvalid1 - v0 !== 1) $display("FAIL b2b_valid_count got %0d want 1", nvalid1 - v0); else n_pass++;
        n_checks++; if (ldata1 !== 40'h00_03_aa_bb_47) $display("FAIL b2b_data got %h want 0003aabb47", ldata1); else n_pass++;
        n_checks++; if (nerr1 - e0 !== 0) $display("FAIL b2b_err_count got %0d want 0", nerr1 - e0); else n_pass++;
        n_checks++; if (vcyc1[v0] !== s + 1) $display("FAIL b2b_latency got %0d want %0d", vcyc1[v0], s + 1); else n_pass++;
        tick(3);
    endtask

    task automatic test_short_frames;
        int v0, s1, s2;
        v0 = nvalid1;
        send_byte(0, 8'h00, 1); send_byte(0, 8'h02, 1); send_byte(0, 8'h47, 1); send_byte(0, 8'hbb, 1);
        s1 = stop_cyc;
        send_byte(0, 8'h00, 1); send_byte(0, 8'h00, 1);
        s2 = stop_cyc;
        tick(4);
        n_checks++; if (nvalid1 - v0 !== 2) $display("FAIL short_valid_count got %0d want 2", nvalid1 - v0); else n_pass++;
        n_checks++; if (vdata1[v0] !== 40'h00_02_00_bb_47) $display("FAIL short_len2_data got %h want 000200bb47", vdata1[v0]); else n_pass++;
        n_checks++; if (vdata1[v0+1] !== 40'h0) $display("FAIL short_len0_data got %h want 0", vdata1[v0+1]); else n_pass++;
        n_checks++; if (vcyc1[v0] !== s1 + 1) $display("FAIL short_len2_latency got %0d want %0d", vcyc1[v0], s1 + 1); else n_pass++;
        n_checks++; if (vcyc1[v0+1] !== s2 + 1) $display("FAIL short_len0_latency got %0d want %0d", vcyc1[v0+1], s2 + 1); else n_pass++;
        tick(3);
    endtask

    task automatic test_bad_len;
        int v0, e0, s;
        v0 = nvalid1; e0 = nerr1;
        send_byte(0, 8'h00, 1); send_byte(0, 8'h05, 1);
        s = stop_cyc;
        tick(4);
        n_checks++; if (nerr1 - e0 !== 1) $display("FAIL badlen_err_count got %0d want 1", nerr1 - e0); else n_pass++;
        n_checks++; if (lcode1 !== 2'd2) $display("FAIL badlen_code got %0d want 2", lcode1); else n_pass++;
        n_checks++; if (ecyc1 !== s) $display("FAIL badlen_latency got %0d want %0d", ecyc1, s); else n_pass++;
        n_checks++; if (nvalid1 - v0 !== 0) $display("FAIL badlen_no_valid got %0d want 0", nvalid1 - v0); else n_pass++;
        send_byte(0, 8'h00, 1); send_byte(0, 8'h01, 1); send_byte(0, 8'h47, 1);
        tick(4);
        n_checks++; if (nvalid1 - v0 !== 1) $display("FAIL badlen_recover_count got %0d want 1", nvalid1 - v0); else n_pass++;
        n_checks++; if (ldata1 !== 40'h00_01_00_00_47) $display("FAIL badlen_recover_data got %h want 0001000047", ldata1); else n_pass++;
        tick(3);
    endtask

    task automatic test_framing;
        int v0, e0;
        v0 = nvalid1; e0 = nerr1;
        send_byte(0, 8'h00, 1); send_byte(0, 8'h03, 1); send_byte(0, 8'h47, 0);
        tick(5);
        n_checks++; if (nerr1 - e0 !== 1) $display("FAIL framing_err_count got %0d want 1", nerr1 - e0); else n_pass++;
        n_checks++; if (lcode1 !== 2'd1) $display("FAIL framing_code got %0d want 1", lcode1); else n_pass++;
        n_checks++; if (data1 !== 40'h00_01_00_00_47) $display("FAIL framing_data_held got %h want 0001000047", data1); else n_pass++;
        n_checks++; if (nvalid1 - v0 !== 0) $display("FAIL framing_no_valid got %0d want 0", nvalid1 - v0); else n_pass++;
    endtask

    task automatic test_break;
        int e0;
        e0 = nerr1;
        in1 = 1'b0;
        tick(40);
        in1 = 1'b1;
        tick(5);
        n_checks++; if (nerr1 - e0 !== 1) $display("FAIL break_err_count got %0d want 1", nerr1 - e0); else n_pass++;
        n_checks++; if (lcode1 !== 2'd1) $display("FAIL break_code got %0d want 1", lcode1); else n_pass++;
    endtask

    task automatic test_timeout;
        int v0, e0, s;
        v0 = nvalid1; e0 = nerr1;
        send_byte(0, 8'h00, 1); send_byte(0, 8'h03, 1); send_byte(0, 8'h47, 1);
        s = stop_cyc;
        tick(65);
        tick(3);
        n_checks++; if (nerr1 - e0 !== 1) $display("FAIL timeout_err_count got %0d want 1", nerr1 - e0); else n_pass++;
        n_checks++; if (lcode1 !== 2'd3) $display("FAIL timeout_code got %0d want 3", lcode1); else n_pass++;
        n_checks++; if (ecyc1 !== s + 65) $display("FAIL timeout_cycle got %0d want %0d", ecyc1, s + 65); else n_pass++;
        e0 = nerr1;
        send_byte(0, 8'h00, 1); send_byte(0, 8'h03, 1); send_byte(0, 8'h47, 1);
        tick(64);
        send_byte(0, 8'hbb, 1); send_byte(0, 8'haa, 1);
        tick(4);
        n_checks++; if (nvalid1 - v0 !== 1) $display("FAIL gap64_valid_count got %0d want 1", nvalid1 - v0); else n_pass++;
        n_checks++; if (ldata1 !== 40'h00_03_aa_bb_47) $display("FAIL gap64_data got %h want 0003aabb47", ldata1); else n_pass++;
        n_checks++; if (nerr1 - e0 !== 0) $display("FAIL gap64_err_count got %0d want 0", nerr1 - e0); else n_pass++;
        tick(3);
    endtask

    task automatic test_reset_mid_frame;
        int v0, e0;
        v0 = nvalid1; e0 = nerr1;
        send_byte(0, 8'h00, 1); send_byte(0, 8'h03, 1);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1); drive_bit(0, 1'b1); drive_bit(0, 1'b1);
        rst = 1'b1;
        in1 = 1'b1;
        tick(1);
        n_checks++; if (data1 !== 40'h0) $display("FAIL midrst_data_cleared got %h want 0", data1); else n_pass++;
        rst = 1'b0;
        tick(3);
        send_byte(0, 8'h00, 1); send_byte(0, 8'h01, 1); send_byte(0, 8'h5a, 1);
        tick(4);
        n_checks++; if (nvalid1 - v0 !== 1) $display("FAIL midrst_valid_count got %0d want 1", nvalid1 - v0); else n_pass++;
        n_checks++; if (ldata1 !== 40'h00_01_00_00_5a) $display("FAIL midrst_data got %h want 000100005a", ldata1); else n_pass++;
        n_checks++; if (nerr1 - e0 !== 0) $display("FAIL midrst_err_count got %0d want 0", nerr1 - e0); else n_pass++;
    endtask

    task automatic test_cpb4;
        int v0, e0;
        v0 = nvalid4; e0 = nerr4;
        in4 = 1'b0;
        tick(1);
        in4 = 1'b1;
        tick(12);
        n_checks++; if (nvalid4 - v0 !== 0 || nerr4 - e0 !== 0)
            $display("FAIL cpb4_glitch got valid=%0d err=%0d want 0/0", nvalid4 - v0, nerr4 - e0); else n_pass++;
        send_byte(1, 8'h00, 1); send_byte(1, 8'h03, 1); send_byte(1, 8'h47, 1);
        send_byte(1, 8'hbb, 1); send_byte(1, 8'haa, 1);
        tick(10);
        n_checks++; if (nvalid4 - v0 !== 1) $display("FAIL cpb4_valid_count got %0d want 1", nvalid4 - v0); else n_pass++;
        n_checks++; if (ldata4 !== 40'h00_03_aa_bb_47) $display("FAIL cpb4_data got %h want 0003aabb47", ldata4); else n_pass++;
        n_checks++; if (nerr4 - e0 !== 0) $display("FAIL cpb4_err_count got %0d want 0", nerr4 - e0); else n_pass++;
    endtask

    task automatic test_exclusive;
        n_checks++; if (nboth !== 0) $display("FAIL valid_err_overlap got %0d want 0", nboth); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_short_frames();
        test_bad_len();
        test_framing();
        test_break();
        test_timeout();
        test_reset_mid_frame();
        test_cpb4();
        test_exclusive();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
Serial-to-frame receiver: the receiving end of the team's framed UART link driven by uart_tx.
- Deserialises 8N1 bytes from a single-bit line and assembles one frame: CMD byte, LEN byte, then LEN payload bytes.
- Presents the frame as one FULL_DATA_SIZE-bit word with a 1-cycle valid pulse.
- Sits between the serial pin (same clock domain as the transmitter) and the command decoder.

Parameters:
FULL_DATA_SIZE, 40, width of assembled frame word (CMD + LEN + payload); must be a multiple of BYTE_SIZE and >= 2*BYTE_SIZE.
BYTE_SIZE, 8, data bits per UART character.
CLKS_PER_BIT, 1, CLK cycles per serial bit; must be >= 1.
TIMEOUT_CLKS, 64, maximum idle CLK cycles allowed between the stop bit of one byte and the start bit of the next within a frame.

Ports:
CLK  input  1  system clock
RST  input  1  reset; synchronous, active-high
in_bit  input  1  serial line, idle high, synchronous to CLK (same-clock link, no synchronizer)
out_data  output  FULL_DATA_SIZE  assembled frame; held until next out_valid
out_valid  output  1  one-cycle pulse, out_data valid
out_err  output  1  one-cycle pulse, frame aborted
err_code  output  2  cause, valid with out_err: 1=framing (stop bit 0), 2=bad LEN, 3=timeout; held until next out_err

Behaviour:
- Reset: out_data=0, out_valid=0, out_err=0, err_code=0; frame FSM in F_CMD; byte receiver idle. RST mid-frame discards all partial state in the next cycle.
- Byte receiver (LSB first). States are B_IDLE, B_START, B_DATA, B_STOP.
  - B_IDLE: in_bit==0 starts a byte; bit counter = 0.
  - Each bit is sampled when the cycle counter reaches CLKS_PER_BIT/2 (integer division) within that bit. For CLKS_PER_BIT=1, the detect cycle is the start sample and each following cycle is one bit.
  - Start sample ==1 -> glitch; return to B_IDLE with no error.
  - After BYTE_SIZE data samples, the stop bit is sampled. Stop==1 -> byte_valid pulse. Stop==0 -> framing error pulse.
  - After either result, the receiver returns to B_IDLE and may detect a new start on the next cycle.
- Frame FSM. States are F_CMD, F_LEN, F_DATA, F_DONE. MAX_PAY = FULL_DATA_SIZE/BYTE_SIZE - 2 (3 by default).
  - F_CMD: a byte is stored to out-shadow[MSB byte]; the shadow is cleared to 0 first. Go to F_LEN.
  - F_LEN: a byte is stored to the next byte down.
    - LEN > MAX_PAY -> abort, err_code=2.
    - LEN==0 -> F_DONE.
    - Otherwise -> F_DATA with remaining count = LEN.
  - F_DATA: payload byte i (0-based arrival order) goes to bits [BYTE_SIZE*i +: BYTE_SIZE]. Unreceived payload bytes stay 0. Decrement the count; go to F_DONE at 0.
  - F_DONE: out_data <= shadow, out_valid=1 for exactly one cycle, then F_CMD.
  - Latency: out_valid rises 2 cycles after the final stop-bit sample cycle.
- Abort: out_err=1 for one cycle, err_code is set, the shadow is discarded, and the FSM goes to F_CMD. out_data keeps its previous value. Abort causes:
  - framing error in any state (code 1);
  - bad LEN (code 2);
  - idle gap > TIMEOUT_CLKS while in F_LEN or F_DATA (code 3).
- Timeout counter:
  - runs only while the byte receiver is in B_IDLE and the FSM is in F_LEN or F_DATA;
  - clears on each start detect;
  - abort fires on the cycle the count reaches TIMEOUT_CLKS+1.
  - F_CMD has no timeout.
- Simultaneous events:
  - A start bit arriving in the same cycle as F_DONE or an abort is still captured; the byte receiver is independent of the frame FSM.
  - out_valid and out_err never assert in the same cycle.
- Line held low (break): it is received as byte 0x00 with stop==0, giving a framing error. The receiver then re-detects a start only on the next 1->0 transition; B_IDLE requires the line to have been seen high.

Decomposition:
- Shared package uart_pkg holds:
  - BYTE_SIZE and FULL_DATA_SIZE defaults;
  - byte-state and frame-state enums;
  - err_code constants ERR_NONE/FRAMING/LEN/TIMEOUT;
  - MAX_PAY derivation.
- Sub-module uart_byte_rx: bit timing, start/stop check, shift register. Outputs byte, byte_valid, frame_err, idle.
- uart_frame_rx: frame FSM, timeout counter, shadow register.

Test Plan:
- CLKS_PER_BIT=1. Send bytes 00,03,47,bb,aa back-to-back (50 bit-cycles) -> one out_valid, out_data=40'h00_03_aa_bb_47, out_err never set.
- Send 00,02,47,bb -> out_data=40'h00_02_00_bb_47. Then send 00,00 -> out_data=40'h00_00_00_00_00. The second frame starts 1 cycle after the first stop bit.
- Send 00,05 -> out_err pulse 1 cycle after the LEN stop sample, err_code=2, no out_valid. A following valid frame 00,01,47 -> 40'h00_01_00_00_47.
- Send 00,03,47 with stop bit driven 0 -> out_err, err_code=1; out_data unchanged from the previous frame.
- Send 00,03,47, then hold the line high 65 cycles -> out_err, err_code=3. Repeat with a 64-cycle gap then bb,aa -> valid frame 40'h00_03_aa_bb_47.
- Assert RST for 1 cycle in the middle of byte 3, then send a full frame 00,01,5a -> out_data=40'h00_01_00_00_5a, no err. Repeat scenario 1 with CLKS_PER_BIT=4 -> same data.
